mem_line_arbiter: RTL and testbench

Arbiter and sequencer that shares a single-ported line memory backend between the I-cache refill path, the D-cache refill path and D-cache dirty-line write-back. It sits between the two caches and the memory, presenting each cache with its own line-request and line-response interface. Internally it buffers one write-back and always drains it before any read, so a refill never reads stale data. It also guarantees that at most one backend transaction is outstanding.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_wb_buf.sv | 56 +++++
 rtl/mem_line_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_line_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the line-memory arbiter: FSM states, grant sources and
// default widths.
package mem_arb_pkg;

  localparam int XLEN_DEF           = 32;
  localparam int LINE_BITS_DEF      = 16;
  localparam int WORDS_PER_LINE_DEF = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_I, SRC_D, SRC_WB} src_e;

endpackage

// File: rtl/mem_arb_wb_buf.sv
// One-entry D-cache write-back buffer. A push is accepted only while empty;
// pop clears the full flag once the line has been sent to memory.
module mem_arb_wb_buf #(
  parameter int AW = 16,
  parameter int LW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [LW-1:0] push_line,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [LW-1:0] line
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] line_q, line_d;

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    line_d = line_q;
    if (push && !full_q) begin
      full_d = 1'b1;
      addr_d = push_addr;
      line_d = push_line;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      line_q <= line_d;
    end
  end

  // A push into an occupied buffer is dropped; the cache must respect full.
  always @(posedge clk)
    if (!rst) assert (!(push && full_q))
      else $warning("mem_arb_wb_buf: push while occupied, line dropped");

  assign full = full_q;
  assign addr = addr_q;
  assign line = line_q;

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line memory between I refill, D refill and D write-back, one
// transaction at a time. Define MEM_ARB_RR_EN for round-robin I/D reads.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int LINE_BITS      = LINE_BITS_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Ic_mem_req,
  input  logic [LINE_BITS-1:0]           Ic_mem_addr,
  output logic [XLEN*WORDS_PER_LINE-1:0] F_mem_inst,
  output logic                           F_mem_valid,
  input  logic                           Dc_mem_req,
  input  logic [LINE_BITS-1:0]           Dc_mem_addr,
  output logic [XLEN*WORDS_PER_LINE-1:0] MEM_data_line,
  output logic                           MEM_mem_valid,
  input  logic                           Dc_wb_we,
  input  logic [LINE_BITS-1:0]           Dc_wb_addr,
  input  logic [XLEN*WORDS_PER_LINE-1:0] Dc_wb_wline,
  output logic                           Dc_wb_full,
  output logic                           arb_mem_req,
  output logic                           arb_mem_we,
  output logic [LINE_BITS-1:0]           arb_mem_addr,
  output logic [XLEN*WORDS_PER_LINE-1:0] arb_mem_wline,
  input  logic                           mem_rvalid,
  input  logic [XLEN*WORDS_PER_LINE-1:0] mem_rline
);

  localparam int LW = XLEN * WORDS_PER_LINE;

  state_e               state_q, state_d;
  src_e                 src_q, src_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [LINE_BITS-1:0] addr_q, addr_d;
  logic [LW-1:0]        wline_q, wline_d;
  logic [LW-1:0]        f_inst_q, f_inst_d, d_line_q, d_line_d;
  logic                 f_vld_q, f_vld_d, d_vld_q, d_vld_d;
  logic                 ic_req, dc_req, pick_i, pick_d;
  logic                 wb_full;
  logic [LINE_BITS-1:0] wb_addr;
  logic [LW-1:0]        wb_line;
`ifdef MEM_ARB_RR_EN
  logic                 last_d_q, last_d_d;
`endif

  mem_arb_wb_buf #(.AW(LINE_BITS), .LW(LW)) u_wb_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (Dc_wb_we),
    .pop      (state_q == ST_WR),
    .push_addr(Dc_wb_addr),
    .push_line(Dc_wb_wline),
    .full     (wb_full),
    .addr     (wb_addr),
    .line     (wb_line)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    req_d    = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    f_inst_d = f_inst_q;
    f_vld_d  = 1'b0;
    d_line_d = d_line_q;
    d_vld_d  = 1'b0;
    // Mask the source whose response is visible so a held request is not re-granted.
    ic_req   = Ic_mem_req && !f_vld_q;
    dc_req   = Dc_mem_req && !d_vld_q;
`ifdef MEM_ARB_RR_EN
    last_d_d = last_d_q;
    pick_d   = dc_req && (!ic_req || !last_d_q);
`else
    pick_d   = dc_req;
`endif
    pick_i   = ic_req && !pick_d;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_full) begin
          state_d = ST_WR;
          src_d   = SRC_WB;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = wb_addr;
          wline_d = wb_line;
        // A write-back landing this cycle must drain before any read is issued.
        end else if (!Dc_wb_we && (pick_i || pick_d)) begin
          state_d = ST_RD;
          src_d   = pick_d ? SRC_D : SRC_I;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pick_d ? Dc_mem_addr : Ic_mem_addr;
`ifdef MEM_ARB_RR_EN
          last_d_d = pick_d;
`endif
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
      end
      ST_RD: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
          if (src_q == SRC_I) begin
            f_inst_d = mem_rline;
            f_vld_d  = 1'b1;
          end else if (src_q == SRC_D) begin
            d_line_d = mem_rline;
            d_vld_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_NONE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wline_q  <= '0;
      f_inst_q <= '0;
      f_vld_q  <= 1'b0;
      d_line_q <= '0;
      d_vld_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      f_inst_q <= f_inst_d;
      f_vld_q  <= f_vld_d;
      d_line_q <= d_line_d;
      d_vld_q  <= d_vld_d;
`ifdef MEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign F_mem_inst    = f_inst_q;
  assign F_mem_valid   = f_vld_q;
  assign MEM_data_line = d_line_q;
  assign MEM_mem_valid = d_vld_q;
  assign Dc_wb_full    = wb_full;
  assign arb_mem_req   = req_q;
  assign arb_mem_we    = we_q;
  assign arb_mem_addr  = addr_q;
  assign arb_mem_wline = wline_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: stimulus queues expected backend
// requests, responses and level checks; a negedge monitor pops and compares.
module tb_mem_line_arbiter;

  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Ic_mem_req = 1'b0, Dc_mem_req = 1'b0, Dc_wb_we = 1'b0;
  logic [15:0]  Ic_mem_addr = '0, Dc_mem_addr = '0, Dc_wb_addr = '0;
  logic [127:0] Dc_wb_wline = '0;
  logic         mem_rvalid = 1'b0;
  logic [127:0] mem_rline = '0;
  logic [127:0] F_mem_inst, MEM_data_line, arb_mem_wline;
  logic         F_mem_valid, MEM_mem_valid, Dc_wb_full, arb_mem_req, arb_mem_we;
  logic [15:0]  arb_mem_addr;

  mem_line_arbiter dut (
    .clk(clk), .rst(rst),
    .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
    .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
    .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .Dc_wb_full(Dc_wb_full),
    .arb_mem_req(arb_mem_req), .arb_mem_we(arb_mem_we),
    .arb_mem_addr(arb_mem_addr), .arb_mem_wline(arb_mem_wline),
    .mem_rvalid(mem_rvalid), .mem_rline(mem_rline)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic we; logic [15:0] addr; logic [127:0] wline; } req_t;
  typedef struct { int cyc; logic [127:0] data; } rsp_t;
  typedef struct { int cyc; int sig; logic [127:0] val; string name; } lv_t;

  req_t exp_req[$];
  rsp_t exp_i[$], exp_d[$];
  lv_t  lvq[$];
  int   checks = 0, fails = 0;
  logic done = 1'b0;
  int   spur_cyc = -1;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {~a, a, 16'h1111, a, 16'h2222, a, 16'h3333, a};
  endfunction

  // Backend: fixed read latency L, writes land in a sparse memory.
  logic [127:0] bmem [logic [15:0]];
  int           be_cnt = 0;
  logic [15:0]  be_addr = '0;
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (be_cnt > 0) begin
      be_cnt--;
      if (be_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rline  = bmem.exists(be_addr) ? bmem[be_addr] : pat(be_addr);
      end
    end
    if (cyc == spur_cyc) begin
      mem_rvalid = 1'b1;
      mem_rline  = {4{32'hDEADBEEF}};
    end
    if (arb_mem_req === 1'b1) begin
      if (arb_mem_we) bmem[arb_mem_addr] = arb_mem_wline;
      else begin be_cnt = L; be_addr = arb_mem_addr; end
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] get_sig(input int s);
    case (s)
      0: return 128'(Dc_wb_full);
      1: return 128'(arb_mem_req);
      2: return 128'(arb_mem_we);
      3: return 128'(F_mem_valid);
      4: return 128'(MEM_mem_valid);
      5: return 128'(arb_mem_addr);
      6: return F_mem_inst;
      7: return MEM_data_line;
      default: return arb_mem_wline;
    endcase
  endfunction

  initial begin
    req_t r;
    rsp_t p;
    forever begin
      @(negedge clk);
      if (arb_mem_req === 1'b1) begin
        if (exp_req.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_req cyc=%0d got addr=%h we=%b want none", cyc, arb_mem_addr, arb_mem_we);
        end else begin
          r = exp_req.pop_front();
          chk("req_cyc", 128'(cyc), 128'(r.cyc));
          chk("req_we", 128'(arb_mem_we), 128'(r.we));
          chk("req_addr", 128'(arb_mem_addr), 128'(r.addr));
          if (r.we) chk("req_wline", arb_mem_wline, r.wline);
        end
      end
      if (F_mem_valid === 1'b1) begin
        if (exp_i.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_F_valid cyc=%0d got=%h want none", cyc, F_mem_inst);
        end else begin
          p = exp_i.pop_front();
          chk("F_cyc", 128'(cyc), 128'(p.cyc));
          chk("F_data", F_mem_inst, p.data);
        end
      end
      if (MEM_mem_valid === 1'b1) begin
        if (exp_d.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_MEM_valid cyc=%0d got=%h want none", cyc, MEM_data_line);
        end else begin
          p = exp_d.pop_front();
          chk("MEM_cyc", 128'(cyc), 128'(p.cyc));
          chk("MEM_data", MEM_data_line, p.data);
        end
      end
      for (int k = lvq.size() - 1; k >= 0; k--)
        if (lvq[k].cyc == cyc) begin
          chk(lvq[k].name, get_sig(lvq[k].sig), lvq[k].val);
          lvq.delete(k);
        end
      if (done || cyc > 2000) begin
        if (!done) begin
          checks++; fails++;
          $display("FAIL timeout cyc=%0d got no end want done", cyc);
        end
        chk("req_drained", 128'(exp_req.size()), 128'(0));
        chk("i_drained", 128'(exp_i.size()), 128'(0));
        chk("d_drained", 128'(exp_d.size()), 128'(0));
        chk("lv_drained", 128'(lvq.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic ereq(input int c, input logic we, input logic [15:0] a, input logic [127:0] w);
    exp_req.push_back('{cyc: c, we: we, addr: a, wline: w});
  endtask
  task automatic ei(input int c, input logic [127:0] d);
    exp_i.push_back('{cyc: c, data: d});
  endtask
  task automatic ed(input int c, input logic [127:0] d);
    exp_d.push_back('{cyc: c, data: d});
  endtask
  task automatic lv(input int c, input int s, input logic [127:0] v, input string n);
    lvq.push_back('{cyc: c, sig: s, val: v, name: n});
  endtask

  task automatic do_reset();
    int c;
    rst = 1'b1; Ic_mem_req = 1'b0; Dc_mem_req = 1'b0; Dc_wb_we = 1'b0;
    repeat (3) @(negedge clk);
    c = cyc;
    for (int s = 0; s < 9; s++) lv(c + 1, s, '0, $sformatf("reset_s%0d", s));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W2 = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] W3 = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [127:0] W4 = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;

  initial begin
    int c;
    do_reset();

    // I read alone: req at +1, pulse at +5, no re-grant while held.
    c = cyc;
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'h0012;
    ereq(c + 1, 1'b0, 16'h0012, '0);
    ei(c + 5, pat(16'h0012));
    for (int k = 2; k <= 6; k++) lv(c + k, 1, '0, "t1_no_rereq");
    lv(c + 6, 3, '0, "t1_pulse_one_cycle");
    lv(c + 6, 6, pat(16'h0012), "t1_inst_hold");
    repeat (5) @(negedge clk);
    Ic_mem_req = 1'b0;
    repeat (3) @(negedge clk);

    // Write-back and read of the same line together: write drains first.
    do_reset();
    c = cyc;
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'h0040; Dc_wb_wline = W1;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0040;
    lv(c + 1, 0, 128'd1, "t2_full_set");
    lv(c + 1, 1, '0, "t2_no_early_read");
    ereq(c + 2, 1'b1, 16'h0040, W1);
    lv(c + 3, 0, '0, "t2_full_clear");
    lv(c + 3, 1, '0, "t2_req_one_cycle");
    ereq(c + 4, 1'b0, 16'h0040, '0);
    ed(c + 8, W1);
    @(negedge clk);
    Dc_wb_we = 1'b0;
    repeat (7) @(negedge clk);
    Dc_mem_req = 1'b0;
    repeat (3) @(negedge clk);

    // I and D held together: D, I, D, I.
    do_reset();
    c = cyc;
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'h0021;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0031;
    ereq(c + 1, 1'b0, 16'h0031, '0);  ed(c + 5, pat(16'h0031));
    ereq(c + 6, 1'b0, 16'h0021, '0);  ei(c + 10, pat(16'h0021));
    ereq(c + 11, 1'b0, 16'h0031, '0); ed(c + 15, pat(16'h0031));
    ereq(c + 16, 1'b0, 16'h0021, '0); ei(c + 20, pat(16'h0021));
    lv(c + 21, 1, '0, "t3_idle_after");
    repeat (15) @(negedge clk);
    Dc_mem_req = 1'b0;
    repeat (5) @(negedge clk);
    Ic_mem_req = 1'b0;
    repeat (3) @(negedge clk);

    // After a lone D grant, fresh simultaneous I/D requests show the policy.
    do_reset();
    c = cyc;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0050;
    ereq(c + 1, 1'b0, 16'h0050, '0); ed(c + 5, pat(16'h0050));
    repeat (5) @(negedge clk);
    Dc_mem_req = 1'b0;
    @(negedge clk);
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'h0060;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0051;
`ifdef MEM_ARB_RR_EN
    ereq(c + 7, 1'b0, 16'h0060, '0);  ei(c + 11, pat(16'h0060));
    ereq(c + 12, 1'b0, 16'h0051, '0); ed(c + 16, pat(16'h0051));
    repeat (5) @(negedge clk);
    Ic_mem_req = 1'b0;
    repeat (5) @(negedge clk);
    Dc_mem_req = 1'b0;
`else
    ereq(c + 7, 1'b0, 16'h0051, '0);  ed(c + 11, pat(16'h0051));
    ereq(c + 12, 1'b0, 16'h0060, '0); ei(c + 16, pat(16'h0060));
    repeat (5) @(negedge clk);
    Dc_mem_req = 1'b0;
    repeat (5) @(negedge clk);
    Ic_mem_req = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Push while full is dropped; the first line is what gets written.
    do_reset();
    c = cyc;
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'h0070; Dc_wb_wline = W2;
    lv(c + 1, 0, 128'd1, "t5_full");
    lv(c + 2, 0, 128'd1, "t5_full_held");
    ereq(c + 2, 1'b1, 16'h0070, W2);
    lv(c + 3, 0, '0, "t5_full_clear");
    @(negedge clk);
    Dc_wb_addr = 16'h0071; Dc_wb_wline = W3;
    @(negedge clk);
    Dc_wb_we = 1'b0;
    repeat (4) @(negedge clk);

    // Spurious mem_rvalid in IDLE: no pulse, then a normal read keeps its timing.
    c = cyc;
    spur_cyc = c + 1;
    for (int k = 2; k <= 3; k++) begin
      lv(c + k, 3, '0, "t7_no_F");
      lv(c + k, 4, '0, "t7_no_MEM");
      lv(c + k, 1, '0, "t7_no_req");
    end
    repeat (3) @(negedge clk);
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'h0090;
    ereq(c + 4, 1'b0, 16'h0090, '0);
    ei(c + 8, pat(16'h0090));
    repeat (5) @(negedge clk);
    Ic_mem_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in RD abandons the read and the buffered write-back.
    do_reset();
    c = cyc;
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'h0080;
    ereq(c + 1, 1'b0, 16'h0080, '0);
    @(negedge clk);
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'h0081; Dc_wb_wline = W4;
    lv(c + 2, 0, 128'd1, "t6_full_in_rd");
    @(negedge clk);
    Dc_wb_we = 1'b0; Ic_mem_req = 1'b0; rst = 1'b1;
    for (int s = 0; s < 9; s++) lv(c + 3, s, '0, $sformatf("t6_rst_s%0d", s));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      lv(c + k, 1, '0, "t6_no_req");
      lv(c + k, 3, '0, "t6_no_late_F");
      lv(c + k, 0, '0, "t6_wb_discarded");
    end
    repeat (7) @(negedge clk);

    done = 1'b1;
  end

endmodule
